alu_muldiv_seq: RTL and testbench

Multi-cycle sequencer that executes 32×32 unsigned multiply and unsigned divide by iterating the shared 32-bit ALU. It issues one add or subtract per cycle and consumes the ALU's Result and Carry. The block sits beside the ALU in the execute stage. The ALU is instantiated by the parent, and the parent muxes the ALU inputs to this block while `busy` is high.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_muldiv_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Package  : alu_pkg
// Purpose  : Shared ALU control encodings, mul/div opcodes and the
//            sequencer state type used by the execute-stage multi-cycle unit.
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // ALU control codes driven by the sequencer (others belong to the decoder)
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;

  // Multi-cycle operation select
  localparam logic OP_MULU = 1'b0;
  localparam logic OP_DIVU = 1'b1;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } muldiv_state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq
// Purpose  : 32x32 unsigned multiply / divide sequencer that borrows the
//            shared execute-stage ALU for one add or subtract per cycle.
//            MULU is shift-add, DIVU is restoring division; both take 32
//            iterations. Divide-by-zero finishes immediately with a flag.
// Revision : 1.0  initial release
// ============================================================================
module alu_muldiv_seq
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic        done,
  output logic        dbz,
  output logic [31:0] res_lo,
  output logic [31:0] res_hi,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic        alu_carry
);

  localparam logic [4:0] LAST_ITER = 5'd31;

  muldiv_state_t state_q, state_d;
  logic [31:0]   acc_q, acc_d;
  logic [31:0]   mq_q, mq_d;
  logic [31:0]   dvs_q, dvs_d;
  logic [4:0]    cnt_q, cnt_d;
  logic [31:0]   res_lo_q, res_lo_d;
  logic [31:0]   res_hi_q, res_hi_d;
  logic          dbz_q, dbz_d;

  // Divide step: partial remainder shifted left by one with the next dividend bit.
  // sh[32] set means sh already exceeds any 32-bit divisor, which the ALU carry
  // alone cannot see.
  logic [32:0]   sh;
  logic          qbit;

  assign sh   = {acc_q, mq_q[31]};
  assign qbit = sh[32] | alu_carry;

  // State and datapath registers; async reset clears everything including results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mq_q     <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      dbz_q    <= dbz_d;
    end
  end

  // Next-state, iteration datapath and ALU operand drive
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    dbz_d    = dbz_q;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_MULU) begin
            acc_d   = '0;
            mq_d    = opb;
            dvs_d   = opa;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = ST_MUL;
          end else if (opb == 32'd0) begin
            // Divide-by-zero: canned result, no ALU iterations
            res_lo_d = 32'hFFFF_FFFF;
            res_hi_d = opa;
            dbz_d    = 1'b1;
            state_d  = ST_DONE;
          end else begin
            acc_d   = '0;
            mq_d    = opa;
            dvs_d   = opb;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = ST_DIV;
          end
        end
      end

      ST_MUL: begin
        alu_ctrl = ALU_ADD;
        alu_a    = acc_q;
        alu_b    = mq_q[0] ? dvs_q : 32'd0;
        // 65-bit {carry, sum, multiplier} shifted right by one
        {acc_d, mq_d} = {alu_carry, alu_result, mq_q[31:1]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          res_hi_d = acc_d;
          res_lo_d = mq_d;
          state_d  = ST_DONE;
        end
      end

      ST_DIV: begin
        alu_ctrl = ALU_SUB;
        alu_a    = sh[31:0];
        alu_b    = dvs_q;
        acc_d    = qbit ? alu_result : sh[31:0];
        mq_d     = {mq_q[30:0], qbit};
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) begin
          res_hi_d = acc_d;
          res_lo_d = mq_d;
          state_d  = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status and result outputs decoded from registered state
  always_comb begin
    busy   = (state_q == ST_MUL) || (state_q == ST_DIV);
    done   = (state_q == ST_DONE);
    dbz    = dbz_q;
    res_lo = res_lo_q;
    res_hi = res_hi_q;
  end

endmodule : alu_muldiv_seq
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muldiv_seq
// Purpose  : Self-checking bench for alu_muldiv_seq with an attached ALU
//            model, directed vectors, random ops against 64-bit arithmetic,
//            and multi-cycle corner sequences (ignored start, mid-op reset).
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_muldiv_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        busy;
  logic        done;
  logic        dbz;
  logic [31:0] res_lo;
  logic [31:0] res_hi;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_carry;

  int n_tests = 0;
  int n_fail  = 0;

  alu_muldiv_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .opa        (opa),
    .opb        (opb),
    .busy       (busy),
    .done       (done),
    .dbz        (dbz),
    .res_lo     (res_lo),
    .res_hi     (res_hi),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_carry  (alu_carry)
  );

  // Parent-side ALU: subtract is a + ~b + 1, carry is bit 32 of that sum
  logic [32:0] alu_sum;
  assign alu_sum    = (alu_ctrl == 3'b001) ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1)
                                           : ({1'b0, alu_a} + {1'b0, alu_b});
  assign alu_result = alu_sum[31:0];
  assign alu_carry  = alu_sum[32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic
  task automatic ref_model(input bit o, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] lo, output logic [31:0] hi, output bit z);
    logic [63:0] p;
    if (o == 1'b0) begin
      p  = {32'd0, a} * {32'd0, b};
      lo = p[31:0];
      hi = p[63:32];
      z  = 1'b0;
    end else if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
      z  = 1'b1;
    end else begin
      lo = a / b;
      hi = a % b;
      z  = 1'b0;
    end
  endtask

  // Issue one op from IDLE and check latency, busy length, results and idle state
  task automatic run_and_check(input string name, input bit o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_lo,
                               input logic [31:0] exp_hi, input bit exp_dbz);
    logic [31:0] prev_lo, prev_hi;
    int  lat, busy_n;
    bit  first, held_bad, timeout;
    prev_lo = res_lo; prev_hi = res_hi;
    lat = 1; busy_n = 0; first = 1'b1; held_bad = 1'b0; timeout = 1'b0;
    @(negedge clk);
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0;
    while (!done) begin
      if (busy) begin
        busy_n++;
        if (res_lo !== prev_lo || res_hi !== prev_hi) held_bad = 1'b1;
        if (first) begin
          check({name, " first alu_ctrl"}, {61'd0, alu_ctrl}, {63'd0, o});
          if (o == 1'b0) begin
            check({name, " first alu_a"}, {32'd0, alu_a}, 64'd0);
            check({name, " first alu_b"}, {32'd0, alu_b}, {32'd0, (b[0] ? a : 32'd0)});
          end else begin
            check({name, " first alu_a"}, {32'd0, alu_a}, {63'd0, a[31]});
            check({name, " first alu_b"}, {32'd0, alu_b}, {32'd0, b});
          end
        end
        first = 1'b0;
      end
      @(negedge clk);
      lat++;
      if (lat > 100) begin
        timeout = 1'b1;
        break;
      end
    end
    check({name, " timeout"}, {63'd0, timeout}, 64'd0);
    check({name, " latency"}, lat, exp_dbz ? 64'd1 : 64'd33);
    check({name, " busy cycles"}, busy_n, exp_dbz ? 64'd0 : 64'd32);
    check({name, " res held"}, {63'd0, held_bad}, 64'd0);
    check({name, " res"}, {res_hi, res_lo}, {exp_hi, exp_lo});
    check({name, " dbz"}, {63'd0, dbz}, {63'd0, exp_dbz});
    @(negedge clk);
    check({name, " back idle"}, {62'd0, done, busy}, 64'd0);
    check({name, " idle alu"}, {alu_ctrl, alu_a, alu_b}, 67'd0);
  endtask

  typedef struct {
    string       name;
    bit          o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    bit          z;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int dones;
    bit to;
    logic [31:0] ra, rb, elo, ehi;
    bit ez, ro;

    vecs[0] = '{"mul ff*ff",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0};
    vecs[1] = '{"div 100/7",   1'b1, 32'd100,       32'd7,         32'h0000_000E, 32'h0000_0002, 1'b0};
    vecs[2] = '{"div big dvs", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, 32'h7FFF_FFFE, 1'b0};
    vecs[3] = '{"div by zero", 1'b1, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1};
    vecs[4] = '{"mul 0*x",     1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[5] = '{"div 5/9",     1'b1, 32'd5,         32'd9,         32'h0000_0000, 32'h0000_0005, 1'b0};
    vecs[6] = '{"div x/1",     1'b1, 32'hDEAD_BEEF, 32'd1,         32'hDEAD_BEEF, 32'h0000_0000, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 1'b0; opa = '0; opb = '0;
    #2;
    check("reset outputs", {busy, done, dbz, res_lo, res_hi}, 67'd0);
    check("reset alu", {alu_ctrl, alu_a, alu_b}, 67'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 7; i++)
      run_and_check(vecs[i].name, vecs[i].o, vecs[i].a, vecs[i].b,
                    vecs[i].lo, vecs[i].hi, vecs[i].z);

    // Random ops against the arithmetic reference
    for (int i = 0; i < 24; i++) begin
      ro = $urandom_range(0, 1) == 1;
      ra = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'h8000_0000 | $urandom;
        2:       rb = $urandom_range(1, 255);
        default: rb = $urandom;
      endcase
      ref_model(ro, ra, rb, elo, ehi, ez);
      run_and_check("random", ro, ra, rb, elo, ehi, ez);
    end

    // start during an operation and during DONE must be ignored
    @(negedge clk);
    start = 1'b1; op = 1'b0; opa = 32'd3; opb = 32'd5;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int c = 1; c < 45; c++) begin
      if (c == 10) begin
        start = 1'b1; op = 1'b1; opa = 32'h1234; opb = 32'd0;
      end else if (done) begin
        dones++;
        start = 1'b1; op = 1'b1; opa = 32'h1234; opb = 32'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("ignored start done count", dones, 64'd1);
    check("ignored start res", {res_hi, res_lo}, {32'd0, 32'h0000_000F});
    check("ignored start dbz", {63'd0, dbz}, 64'd0);
    check("ignored start idle", {62'd0, busy, done}, 64'd0);

    // Reset mid-multiply, after results are known non-zero
    run_and_check("pre-reset mul", 1'b0, 32'h1234_5678, 32'h9ABC_DEF1,
                  32'h1234_5678 * 32'h9ABC_DEF1,
                  32'(({32'd0, 32'h1234_5678} * {32'd0, 32'h9ABC_DEF1}) >> 32), 1'b0);
    @(negedge clk);
    start = 1'b1; op = 1'b0; opa = 32'hCAFE_F00D; opb = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    check("busy before reset", {63'd0, busy}, 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid reset outputs", {busy, done, dbz, res_lo, res_hi}, 67'd0);
    check("mid reset alu", {alu_ctrl, alu_a, alu_b}, 67'd0);
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dones++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("no done after reset", dones, 64'd0);
    run_and_check("post-reset mul 2*2", 1'b0, 32'd2, 32'd2, 32'd4, 32'd0, 1'b0);

    to = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_alu_muldiv_seq
`default_nettype wire
